// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM plus a memory-mapped peripheral page
// (GPIO, free-running cycle counter, compare timer, sticky status, store counter).
// Loads are combinational from addr and current state; stores commit on the next posedge.
module data_mem_mmio #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] DataWrite,
  output logic [31:0] DataRead,
  output logic [31:0] gpio_out,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Word offsets (addr[7:2]) of the peripheral registers
  localparam logic [5:0] OFF_GPIO   = 6'h00;
  localparam logic [5:0] OFF_CYCLE  = 6'h01;
  localparam logic [5:0] OFF_CMP    = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_IRQEN  = 6'h04;
  localparam logic [5:0] OFF_SCNT   = 6'h05;

  localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] gpio_q,   gpio_d;
  logic [DW-1:0] cycle_q,  cycle_d;
  logic [DW-1:0] cmp_q,    cmp_d;
  logic [2:0]    status_q, status_d;
  logic          irq_en_q, irq_en_d;
  logic [DW-1:0] scnt_q,   scnt_d;
  logic          irq_q,    irq_d;

  logic          ram_hit_c;
  logic          mmio_hit_c;
  logic          misalign_c;
  logic [5:0]    off_c;
  logic [AW-1:0] ram_idx_c;

  logic          wr_ram_c;
  logic          wr_gpio_c;
  logic          wr_cmp_c;
  logic          wr_status_c;
  logic          wr_irqen_c;
  logic          err_misalign_c;
  logic          err_unmapped_c;
  logic          accepted_c;

  // Address decode from addr only; low two bits ignored for selection
  always_comb begin
    ram_hit_c  = (addr[31:16] == 16'h0000) && (32'({18'd0, addr[15:2]}) < 32'(DEPTH));
    mmio_hit_c = (addr[31:16] == MMIO_BASE[31:16]);
    misalign_c = (addr[1:0] != 2'b00);
    off_c      = addr[7:2];
    ram_idx_c  = addr[AW+1:2];
  end

  // Combinational, side-effect-free load path
  always_comb begin
    DataRead = '0;
    if (ram_hit_c) begin
      DataRead = mem_q[ram_idx_c];
    end else if (mmio_hit_c) begin
      case (off_c)
        OFF_GPIO:   DataRead = gpio_q;
        OFF_CYCLE:  DataRead = cycle_q;
        OFF_CMP:    DataRead = cmp_q;
        OFF_STATUS: DataRead = DW'(status_q);
        OFF_IRQEN:  DataRead = DW'(irq_en_q);
        OFF_SCNT:   DataRead = scnt_q;
        default:    DataRead = '0;
      endcase
    end
  end

  // Store classification: which target takes it, or which error flag it raises
  always_comb begin
    wr_ram_c       = 1'b0;
    wr_gpio_c      = 1'b0;
    wr_cmp_c       = 1'b0;
    wr_status_c    = 1'b0;
    wr_irqen_c     = 1'b0;
    err_misalign_c = 1'b0;
    err_unmapped_c = 1'b0;
    if (MemWrite) begin
      if (misalign_c) begin
        err_misalign_c = 1'b1;
      end else if (ram_hit_c) begin
        wr_ram_c = 1'b1;
      end else if (mmio_hit_c) begin
        case (off_c)
          OFF_GPIO:   wr_gpio_c   = 1'b1;
          OFF_CMP:    wr_cmp_c    = 1'b1;
          OFF_STATUS: wr_status_c = 1'b1;
          OFF_IRQEN:  wr_irqen_c  = 1'b1;
          OFF_CYCLE,
          OFF_SCNT:   ;  // read-only: silently ignored
          default:    err_unmapped_c = 1'b1;
        endcase
      end else begin
        err_unmapped_c = 1'b1;
      end
    end
    accepted_c = wr_ram_c | wr_gpio_c | wr_cmp_c | wr_irqen_c;
  end

  // Register next-state: sticky status with set-over-clear priority
  always_comb begin
    gpio_d   = wr_gpio_c  ? DataWrite    : gpio_q;
    cmp_d    = wr_cmp_c   ? DataWrite    : cmp_q;
    irq_en_d = wr_irqen_c ? DataWrite[0] : irq_en_q;
    cycle_d  = cycle_q + DW'(1);
    scnt_d   = scnt_q;
    if (accepted_c && (scnt_q != ALL_ONES)) begin
      scnt_d = scnt_q + DW'(1);
    end
    status_d = status_q;
    if (wr_status_c) begin
      status_d = status_q & ~DataWrite[2:0];
    end
    status_d = status_d | {err_unmapped_c, err_misalign_c, (cycle_q == cmp_q)};
    irq_d    = status_d[0] & irq_en_d;
  end

  // Peripheral registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q   <= '0;
      cycle_q  <= '0;
      cmp_q    <= ALL_ONES;
      status_q <= '0;
      irq_en_q <= 1'b0;
      scnt_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      scnt_q   <= scnt_d;
      irq_q    <= irq_d;
    end
  end

  // RAM write port; contents survive reset, stores during reset are dropped
  always_ff @(posedge clk) begin
    if (wr_ram_c && !rst) begin
      mem_q[ram_idx_c] <= DataWrite;
    end
  end

  assign gpio_out = gpio_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized + directed bench for data_mem_mmio against a per-cycle behavioural model.
module tb_data_mem_mmio;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] A_GPIO   = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
  localparam logic [31:0] A_IRQEN  = 32'hFFFF_0010;
  localparam logic [31:0] A_SCNT   = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] DataWrite;
  logic [31:0] DataRead;
  logic [31:0] gpio_out;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_ram [DEPTH];
  logic [31:0] m_gpio, m_cycle, m_cmp, m_status, m_irqen, m_cnt;

  data_mem_mmio #(.DEPTH(DEPTH), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .DataWrite (DataWrite),
    .DataRead  (DataRead),
    .gpio_out  (gpio_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_is_ram(input logic [31:0] a);
    return (a[31:16] == 16'h0) && (int'(a[15:2]) < int'(DEPTH));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (m_is_ram(w)) return m_ram[int'(w[15:2])];
    if (w[31:16] != 16'hFFFF) return 32'h0;
    case (w[7:0])
      8'h00: return m_gpio;
      8'h04: return m_cycle;
      8'h08: return m_cmp;
      8'h0C: return m_status;
      8'h10: return m_irqen;
      8'h14: return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the architectural rules
  task automatic m_update(input logic we, input logic [31:0] a, input logic [31:0] d, input logic r);
    logic [31:0] set, clr;
    bit acc;
    if (r) begin
      m_gpio = 0; m_cycle = 0; m_cmp = 32'hFFFF_FFFF; m_status = 0; m_irqen = 0; m_cnt = 0;
      return;
    end
    set = (m_cycle == m_cmp) ? 32'h1 : 32'h0;
    clr = 0;
    acc = 0;
    if (we) begin
      if (a[1:0] != 2'b00) set |= 32'h2;
      else if (m_is_ram(a)) begin m_ram[int'(a[15:2])] = d; acc = 1; end
      else if (a[31:16] == 16'hFFFF) begin
        case (a[7:0])
          8'h00: begin m_gpio = d; acc = 1; end
          8'h08: begin m_cmp = d; acc = 1; end
          8'h0C: clr = d & 32'h7;
          8'h10: begin m_irqen = d & 32'h1; acc = 1; end
          8'h04, 8'h14: ;
          default: set |= 32'h4;
        endcase
      end else set |= 32'h4;
    end
    m_status = (m_status & ~clr) | set;
    m_cycle  = m_cycle + 1;
    if (acc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  // Drive one cycle, compare outputs mid-cycle, then advance the model at the edge
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic r,
                      output logic [31:0] rd, output logic [31:0] go, output logic iq);
    @(negedge clk);
    MemWrite = we; addr = a; DataWrite = d; rst = r;
    #1;
    rd = DataRead; go = gpio_out; iq = irq;
    check("DataRead", DataRead, m_read(a));
    check("gpio_out", gpio_out, m_gpio);
    check("irq", {31'b0, irq}, {31'b0, m_status[0] & m_irqen[0]});
    @(posedge clk);
    m_update(we, a, d, r);
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag,
                      output logic [31:0] go, output logic iq);
    logic [31:0] rd;
    step(1'b0, a, 32'h0, 1'b0, rd, go, iq);
    check(tag, rd, exp);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      2:    a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      3, 4: begin
        a = 32'hFFFF_0000 | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 7) == 0) a[15:8] = 8'($urandom);
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      end
      default: begin
        if ($urandom_range(0, 1) == 1) a = 32'h0000_0400 + (32'($urandom_range(0, 255)) << 2);
        else a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
      end
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] rd, go, a, d;
    logic iq;
    MemWrite = 0; addr = 0; DataWrite = 0; rst = 1;
    for (int i = 0; i < DEPTH; i++) m_ram[i] = 32'h0;
    m_update(1'b0, 32'h0, 32'h0, 1'b1);

    step(0, 0, 0, 1, rd, go, iq);
    for (int i = 0; i < DEPTH; i++) step(1, 32'(i) << 2, $urandom, 0, rd, go, iq);
    step(0, 0, 0, 1, rd, go, iq);

    // Reset values
    peek(A_CYCLE,  32'h0,         "rst_cycle",  go, iq);
    peek(A_GPIO,   32'h0,         "rst_gpio",   go, iq);
    peek(A_CMP,    32'hFFFF_FFFF, "rst_cmp",    go, iq);
    peek(A_STATUS, 32'h0,         "rst_status", go, iq);
    peek(A_IRQEN,  32'h0,         "rst_irqen",  go, iq);
    peek(A_SCNT,   32'h0,         "rst_scnt",   go, iq);

    // RAM store/load
    step(1, 32'h10, 32'hDEAD_BEEF, 0, rd, go, iq);
    peek(32'h10, 32'hDEAD_BEEF, "ram_load", go, iq);
    peek(A_SCNT, 32'h1, "scnt_one", go, iq);

    // Misaligned and unmapped stores
    step(1, 32'h13, 32'h1234_5678, 0, rd, go, iq);
    peek(32'h13, 32'hDEAD_BEEF, "misalign_load", go, iq);
    peek(A_STATUS, 32'h2, "status_misal", go, iq);
    step(1, 32'h8000_0000, 32'h5, 0, rd, go, iq);
    peek(A_STATUS, 32'h6, "status_unmap", go, iq);
    peek(A_SCNT, 32'h1, "scnt_unchanged", go, iq);
    peek(32'h8000_0000, 32'h0, "unmapped_load", go, iq);
    step(1, A_STATUS, 32'h6, 0, rd, go, iq);
    peek(A_STATUS, 32'h0, "status_w1c", go, iq);

    // Timer / IRQ
    step(0, 0, 0, 1, rd, go, iq);
    step(1, A_IRQEN, 32'h1, 0, rd, go, iq);
    step(1, A_CMP, 32'd20, 0, rd, go, iq);
    for (int k = 0; k < 100 && m_cycle != 32'd20; k++) step(0, A_CYCLE, 0, 0, rd, go, iq);
    peek(A_CYCLE, 32'd20, "cycle_20", go, iq);
    check("irq_before", {31'b0, iq}, 32'h0);
    peek(A_STATUS, 32'h1, "status_match", go, iq);
    check("irq_rise", {31'b0, iq}, 32'h1);
    step(1, A_STATUS, 32'h1, 0, rd, go, iq);
    peek(A_STATUS, 32'h0, "status_clr", go, iq);
    check("irq_fall", {31'b0, iq}, 32'h0);

    // W1C coinciding with a timer match
    d = m_cycle + 32'd3;
    step(1, A_CMP, d, 0, rd, go, iq);
    for (int k = 0; k < 10 && m_cycle != d; k++) step(0, A_CYCLE, 0, 0, rd, go, iq);
    step(1, A_STATUS, 32'h1, 0, rd, go, iq);
    peek(A_STATUS, 32'h1, "set_beats_w1c", go, iq);

    // Reset mid-run
    step(1, A_GPIO, 32'hA5, 0, rd, go, iq);
    step(1, 32'h0, 32'h7, 0, rd, go, iq);
    for (int k = 0; k < 200 && m_cycle <= 32'd100; k++) step(0, A_CYCLE, 0, 0, rd, go, iq);
    step(1, A_GPIO, 32'hFF, 1, rd, go, iq);
    peek(A_CYCLE, 32'h0, "rst_mid_cycle", go, iq);
    check("rst_mid_gpio", go, 32'h0);
    peek(A_STATUS, 32'h0, "rst_mid_status", go, iq);
    peek(32'h0, 32'h7, "ram_survives", go, iq);

    // Read-only registers and saturation
    step(1, A_CYCLE, 32'h123, 0, rd, go, iq);
    peek(A_CYCLE, m_cycle, "cycle_ro", go, iq);
    peek(A_STATUS, 32'h0, "ro_noflag", go, iq);
    force dut.scnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.scnt_q;
    m_cnt = 32'hFFFF_FFFE;
    step(1, 32'h20, 32'h1, 0, rd, go, iq);
    peek(A_SCNT, 32'hFFFF_FFFF, "scnt_full", go, iq);
    step(1, 32'h24, 32'h2, 0, rd, go, iq);
    step(1, A_GPIO, 32'h3, 0, rd, go, iq);
    peek(A_SCNT, 32'hFFFF_FFFF, "scnt_sat", go, iq);

    // Random traffic
    step(0, 0, 0, 1, rd, go, iq);
    for (int n = 0; n < 3000; n++) begin
      a = rand_addr();
      d = $urandom;
      if (a == A_CMP && $urandom_range(0, 1) == 1) d = m_cycle + 32'($urandom_range(1, 6));
      if (a == A_STATUS) d = 32'($urandom_range(0, 7));
      step(1'($urandom_range(0, 2) != 0), a, d, 1'($urandom_range(0, 199) == 0), rd, go, iq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
